stereo_sad_disparity: RTL and testbench
=======================================

# stereo_sad_disparity

Streaming stereo-matching stage that turns rectified left/right 8-bit grayscale pixel streams into a raster-order disparity stream on `clk_data`. It computes a horizontal-window SAD per candidate disparity and picks the winner (winner-take-all). Its `addr`/`data` output drives the proximity buzzer stage directly, and the display path can tap it.

## Interface
- `WIDTH`, 160: pixels per row.
- `HEIGHT`, 120: rows per frame; last address is WIDTH*HEIGHT-1 = 19199.
- `MAX_DISP`, 16: number of candidate disparities, d = 0..MAX_DISP-1.
- `WIN`, 5: horizontal SAD window length, in pixels.
- `SCALE_SHIFT`, 4: output scaling, data = min(d << SCALE_SHIFT, 255).

Ports:
- `clk_data` in 1: pixel clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `frame_start` in 1: marks the first pixel of a frame; only meaningful when `pix_valid`=1.
- `pix_valid` in 1: `left_pix`/`right_pix` are valid this cycle.
- `left_pix` in 8: left-camera pixel.
- `right_pix` in 8: right-camera pixel, same (x,y) as `left_pix`.
- `addr` out 15: raster address y*WIDTH+x of the output pixel.
- `data` out 8: scaled disparity.
- `data_valid` out 1: `addr`/`data` updated this cycle.
- `frame_done` out 1: 1-cycle pulse together with the output at address WIDTH*HEIGHT-1.

## Operation
- Sync flag:
  - Cleared by reset.
  - Set by a valid pixel with `frame_start`=1.
  - Cleared after the valid pixel at (WIDTH-1, HEIGHT-1) is accepted.
  - Valid pixels arriving while the flag is clear are discarded and produce no output.
- Counters x and y:
  - Advance only on accepted pixels.
  - A `frame_start` pixel forces x=0, y=0.
  - x wraps at WIDTH-1, incrementing y.
- Right delay line R[0..MAX_DISP-1]:
  - R[0] is the current `right_pix`; R[d] is the right pixel d columns to the left.
  - Shifts only on accepted pixels.
- Per-pixel cost terms:
  - ad_d = |left_pix − R[d]|, 8 bits.
  - Each d keeps a WIN-deep history of ad_d, shifted on accepted pixels.
  - cost_d = sum of the WIN history entries, 11 bits unsigned. No saturation is needed, since 5*255 = 1275.
- Eligibility:
  - Candidate d is eligible iff x ≥ d + WIN − 1.
  - This keeps each window inside the current row and inside valid right data; history left over from the previous row is never used.
- Winner selection:
  - d* = eligible d with minimum cost_d; ties go to the smallest d.
  - If no candidate is eligible (x < WIN−1), d* = 0.
- Output: data = min(d* << SCALE_SHIFT, 255); addr = y*WIDTH + x of the same pixel.
- Mid-frame `frame_start`: counters resync to (0,0). Pixels already in flight still emerge with their original addresses.
- Between valid outputs, `addr` and `data` hold their last values. This matters because the buzzer stage samples them every cycle.

## Timing
- Reset values: `addr`=0, `data`=0, `data_valid`=0, `frame_done`=0. All history, delay line, counters and pipeline valids are cleared.
- The pipeline never stalls and always advances; bubbles travel as valid=0.
  - Stage 1: AD registers, plus x, y, valid.
  - Stage 2: window-sum registers.
  - Stage 3: argmin and eligibility register.
  - Stage 4: output registers.
- Fixed latency: a pixel accepted at edge N appears on `addr`/`data`, with `data_valid`=1, after edge N+3 (visible during cycle N+3..N+4).
- Back-to-back valid pixels give back-to-back outputs at one pixel per clock. Gaps in `pix_valid` reappear as identical gaps on `data_valid`.
- `frame_done` is high exactly in the cycle where `data_valid`=1 and `addr`=WIDTH*HEIGHT−1.
- Reset mid-frame: outputs clear immediately (asynchronous). In-flight pixels are lost. Nothing is output until the next `frame_start`.

## Test plan
- **Identical images:** L=R, random texture, one full frame → 19200 outputs, `addr` 0..19199 in order, every `data`=0, a single `frame_done` at 19199.
- **Known shift:** textured rows with `right_pix`(x) = `left_pix`(x+5) → `data`=80 for x≥9; `data`=0 for x<4; `data` ≤ 80 for x=4..8.
- **Flat image:** all pixels 128 → all costs equal; tie-break gives `data`=0 everywhere.
- **Max disparity and saturation:** shift of 15 → `data`=240. Rerun with SCALE_SHIFT=5 → `data`=255.
- **Bubbles:** `pix_valid` alternating 1,0 → each `data_valid` pulse exactly 3 cycles after its input; `addr`/`data` stable during gaps; results identical to the gapless run.
- **Mid-frame disturbances:**
  - Assert `rst_n` low at pixel 5000 → outputs 0 at once.
  - Then feed valid pixels without `frame_start` → no `data_valid`.
  - Then assert `frame_start` → outputs resume with `addr`=0 three cycles later.
  - Separately, a mid-frame `frame_start` without reset → addresses restart at 0.

Source files
------------

// File: rtl/stereo_sad_disparity.sv
// stereo_sad_disparity: streaming horizontal-window SAD stereo matcher with winner-take-all disparity output.
// Four-stage pipeline (AD/history, window sum, argmin, output) that never stalls; bubbles flow as valid=0.
module stereo_sad_disparity #(
  parameter int WIDTH       = 160,
  parameter int HEIGHT      = 120,
  parameter int MAX_DISP    = 16,
  parameter int WIN         = 5,
  parameter int SCALE_SHIFT = 4
) (
  input  logic        clk_data,
  input  logic        rst_n,
  input  logic        frame_start,
  input  logic        pix_valid,
  input  logic [7:0]  left_pix,
  input  logic [7:0]  right_pix,
  output logic [14:0] addr,
  output logic [7:0]  data,
  output logic        data_valid,
  output logic        frame_done
);
  localparam int XW   = $clog2(WIDTH);
  localparam int YW   = $clog2(HEIGHT);
  localparam int DW   = $clog2(MAX_DISP);
  localparam int CW   = $clog2(WIN * 255 + 1);
  localparam int LAST = WIDTH * HEIGHT - 1;

  logic          accept, end_x, end_y;
  logic [XW-1:0] px;
  logic [YW-1:0] py;
  logic [14:0]   pa;
  logic [7:0]    rv [MAX_DISP];
  logic [DW-1:0] best;
  logic [CW-1:0] bc;
  logic [DW+15:0] sc;

  logic          sync_q, sync_d;
  logic [XW-1:0] cx_q, cx_d;
  logic [YW-1:0] cy_q, cy_d;
  logic [14:0]   ca_q, ca_d;
  logic [7:0]    rd_q [MAX_DISP-1];
  logic [7:0]    rd_d [MAX_DISP-1];
  logic [7:0]    hist_q [MAX_DISP][WIN];
  logic [7:0]    hist_d [MAX_DISP][WIN];
  logic [CW-1:0] cost_q [MAX_DISP];
  logic [CW-1:0] cost_d [MAX_DISP];
  logic          v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic [XW-1:0] x1_q, x1_d, x2_q, x2_d;
  logic [14:0]   a1_q, a1_d, a2_q, a2_d, a3_q, a3_d;
  logic [DW-1:0] d3_q, d3_d;
  logic [14:0]   addr_q, addr_d;
  logic [7:0]    data_q, data_d;
  logic          dv_q, dv_d, fd_q, fd_d;

  always_comb begin
    accept = pix_valid && (frame_start || sync_q);
    px     = frame_start ? '0 : cx_q;
    py     = frame_start ? '0 : cy_q;
    pa     = frame_start ? '0 : ca_q;
    end_x  = px == XW'(WIDTH - 1);
    end_y  = py == YW'(HEIGHT - 1);
    sync_d = accept && end_x && end_y ? 1'b0 : pix_valid && frame_start ? 1'b1 : sync_q;
    cx_d   = accept ? (end_x ? '0 : px + 1'b1) : cx_q;
    cy_d   = accept && end_x ? (end_y ? '0 : py + 1'b1) : cy_q;
    ca_d   = accept ? (end_x && end_y ? '0 : pa + 1'b1) : ca_q;
    // rv[d] is the right pixel d columns to the left of the current one
    rv[0] = right_pix;
    for (int d = 1; d < MAX_DISP; d++) rv[d] = rd_q[d-1];
    rd_d[0] = accept ? right_pix : rd_q[0];
    for (int d = 1; d < MAX_DISP - 1; d++) rd_d[d] = accept ? rd_q[d-1] : rd_q[d];
    for (int d = 0; d < MAX_DISP; d++) begin
      hist_d[d][0] = accept ? (left_pix > rv[d] ? left_pix - rv[d] : rv[d] - left_pix) : hist_q[d][0];
      for (int k = 1; k < WIN; k++) hist_d[d][k] = accept ? hist_q[d][k-1] : hist_q[d][k];
      cost_d[d] = '0;
      for (int k = 0; k < WIN; k++) cost_d[d] = cost_d[d] + CW'(hist_q[d][k]);
    end
    v1_d = accept;
    x1_d = px;
    a1_d = pa;
    v2_d = v1_q;
    x2_d = x1_q;
    a2_d = a1_q;
    // strict < keeps the smallest d on ties; bc starts above any reachable cost
    best = '0;
    bc   = '1;
    for (int d = 0; d < MAX_DISP; d++)
      if (int'(x2_q) >= d + WIN - 1 && cost_q[d] < bc) begin
        best = DW'(d);
        bc   = cost_q[d];
      end
    v3_d   = v2_q;
    a3_d   = a2_q;
    d3_d   = best;
    sc     = (DW+16)'(d3_q) << SCALE_SHIFT;
    addr_d = v3_q ? a3_q : addr_q;
    data_d = v3_q ? (sc > (DW+16)'(255) ? 8'hff : sc[7:0]) : data_q;
    dv_d   = v3_q;
    fd_d   = v3_q && a3_q == 15'(LAST);
  end

  always_ff @(posedge clk_data or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 1'b0;
      cx_q   <= '0;
      cy_q   <= '0;
      ca_q   <= '0;
      rd_q   <= '{default: '0};
      hist_q <= '{default: '0};
      cost_q <= '{default: '0};
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      v3_q   <= 1'b0;
      x1_q   <= '0;
      x2_q   <= '0;
      a1_q   <= '0;
      a2_q   <= '0;
      a3_q   <= '0;
      d3_q   <= '0;
      addr_q <= '0;
      data_q <= '0;
      dv_q   <= 1'b0;
      fd_q   <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cx_q   <= cx_d;
      cy_q   <= cy_d;
      ca_q   <= ca_d;
      rd_q   <= rd_d;
      hist_q <= hist_d;
      cost_q <= cost_d;
      v1_q   <= v1_d;
      v2_q   <= v2_d;
      v3_q   <= v3_d;
      x1_q   <= x1_d;
      x2_q   <= x2_d;
      a1_q   <= a1_d;
      a2_q   <= a2_d;
      a3_q   <= a3_d;
      d3_q   <= d3_d;
      addr_q <= addr_d;
      data_q <= data_d;
      dv_q   <= dv_d;
      fd_q   <= fd_d;
    end
  end

  assign addr       = addr_q;
  assign data       = data_q;
  assign data_valid = dv_q;
  assign frame_done = fd_q;
endmodule

// File: tb/tb_stereo_sad_disparity.sv
// tb_stereo_sad_disparity: directed stereo frames with known shifts, checked three cycles after each input.
module tb_stereo_sad_disparity;
  logic        clk_data = 0, rst_n = 0, frame_start = 0, pix_valid = 0;
  logic [7:0]  left_pix = 0, right_pix = 0;
  logic [14:0] addr, addr2;
  logic [7:0]  data, data2;
  logic        data_valid, frame_done, dv2, fd2;
  int vectors = 0, miscompares = 0;

  typedef struct {bit v; int a; int d; bit ex;} exp_t;
  exp_t q[$];
  exp_t idle = '{v: 0, a: 0, d: 0, ex: 1};
  int   last_a = 0, last_d = 0;
  bit   last_ex = 1;
  logic [7:0] tex [176];

  always #5 clk_data = ~clk_data;

  stereo_sad_disparity u_dut (
    .clk_data(clk_data), .rst_n(rst_n), .frame_start(frame_start), .pix_valid(pix_valid),
    .left_pix(left_pix), .right_pix(right_pix), .addr(addr), .data(data),
    .data_valid(data_valid), .frame_done(frame_done));

  stereo_sad_disparity #(.SCALE_SHIFT(5)) u_sat (
    .clk_data(clk_data), .rst_n(rst_n), .frame_start(frame_start), .pix_valid(pix_valid),
    .left_pix(left_pix), .right_pix(right_pix), .addr(addr2), .data(data2),
    .data_valid(dv2), .frame_done(fd2));

  function automatic int scale(int d, int sh);
    int s = d << sh;
    return s > 255 ? 255 : s;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp, input bit le);
    vectors++;
    assert (le ? (got <= exp) : (got === exp)) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %s%0d", tag, got, le ? "<=" : "", exp);
    end
  endtask

  task automatic step(input logic v, input logic fs, input logic [7:0] l, input logic [7:0] r, input exp_t e);
    exp_t o;
    pix_valid = v; frame_start = fs; left_pix = l; right_pix = r;
    q.push_back(e);
    @(posedge clk_data); #1;
    if (q.size() > 3) begin
      o = q.pop_front();
      check("data_valid", 32'(data_valid), 32'(o.v), 0);
      if (o.v) begin
        check("addr", 32'(addr), o.a, 0);
        check("frame_done", 32'(frame_done), 32'(o.a == 19199), 0);
        check("data", 32'(data), scale(o.d, 4), !o.ex);
        check("data_sat", 32'(data2), scale(o.d, 5), !o.ex);
        last_a = o.a; last_d = scale(o.d, 4); last_ex = o.ex;
      end else begin
        check("frame_done_idle", 32'(frame_done), 0, 0);
        check("addr_hold", 32'(addr), last_a, 0);
        if (last_ex) check("data_hold", 32'(data), last_d, 0);
      end
    end
  endtask

  // right(x) = left(x+s) per row, so disparity s wins once its window is fully eligible
  task automatic run(input int n, input int s, input bit bub, input bit flat);
    exp_t e;
    int   x;
    for (int p = 0; p < n; p++) begin
      x = p % 160;
      if (x == 0) for (int i = 0; i < 176; i++) tex[i] = 8'($urandom);
      e.v = 1; e.a = p;
      if (flat || x < 4)  begin e.d = 0;     e.ex = 1; end
      else if (x >= s + 4) begin e.d = s;   e.ex = 1; end
      else                begin e.d = x - 4; e.ex = 0; end
      step(1, p == 0, flat ? 8'd128 : tex[x], flat ? 8'd128 : tex[x+s], e);
      if (bub) step(0, 0, 8'd0, 8'd0, idle);
    end
  endtask

  task automatic check_zero();
    check("rst_addr", 32'(addr), 0, 0);
    check("rst_data", 32'(data), 0, 0);
    check("rst_valid", 32'(data_valid), 0, 0);
    check("rst_done", 32'(frame_done), 0, 0);
  endtask

  initial begin
    #12;
    check_zero();
    @(negedge clk_data) rst_n = 1;
    run(19200, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(1, 0, 8'($urandom), 8'($urandom), idle);
    run(480, 5, 0, 0);
    run(320, 15, 1, 0);
    run(160, 0, 0, 1);
    run(5000, 0, 0, 0);
    #1 rst_n = 0;
    #1 check_zero();
    q.delete(); last_a = 0; last_d = 0; last_ex = 1;
    #2 rst_n = 1;
    for (int i = 0; i < 20; i++) step(1, 0, 8'($urandom), 8'($urandom), idle);
    run(200, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 8'd0, 8'd0, idle);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
